// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants and types: BCD digit geometry, moduli, ms timebase, max time.
// Digit index 0 is ms ones, index 6 is minute tens.
package stopwatch_pkg;

    localparam int BCD_W         = 4;
    localparam int NUM_DIGITS    = 7;
    localparam int DEC_MOD       = 10;
    localparam int SEX_MOD       = 6;
    localparam int CYCLES_PER_MS = 16000;

    typedef logic [BCD_W-1:0]                  bcd_t;
    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0]  digits_t;

    // 59:59.999 packed as {min1,min0,sec1,sec0,ms2,ms1,ms0}
    localparam digits_t MAX_TIME = 28'h5959999;
    localparam int      MAX_MS   = 3599999;

    // Seconds tens and minute tens count modulo 6, everything else modulo 10
    function automatic int digit_mod(input int idx);
        return ((idx == 4) || (idx == 6)) ? SEX_MOD : DEC_MOD;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter with enable-in / carry-out for cascading.
// Updates on the enabled edge; carry_out is combinational from en_in and the current digit.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int MODULO = 10
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             clear,
    input  logic             en_in,
    output logic [BCD_W-1:0] q,
    output logic             carry_out
);

    logic [BCD_W-1:0] r_q;
    logic             w_at_top;

    assign w_at_top  = (r_q == BCD_W'(MODULO - 1));
    assign carry_out = en_in & w_at_top;
    assign q         = r_q;

    // The >= guard keeps the digit legal even if it were ever disturbed out of range
    always_ff @(posedge I_CLK) begin
        if (I_RST || clear) begin
            r_q <= '0;
        end else if (en_in) begin
            r_q <= (r_q >= BCD_W'(MODULO - 1)) ? '0 : r_q + BCD_W'(1);
        end
    end

endmodule

// File: rtl/sw_time_counter.sv
// Stopwatch MM:SS.mmm BCD time base with lap freeze, overflow handling and a registered display.
// Tick at edge N shows on the display after edge N; lap freezes/releases from the following cycle.
module sw_time_counter
    import stopwatch_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             I_EN_1MS,
    input  logic             I_START_EN,
    input  logic             I_CLEAR_EN,
    input  logic             I_LAP,
    output logic [BCD_W-1:0] O_MS2,
    output logic [BCD_W-1:0] O_MS1,
    output logic [BCD_W-1:0] O_MS0,
    output logic [BCD_W-1:0] O_SEC1,
    output logic [BCD_W-1:0] O_SEC0,
    output logic [BCD_W-1:0] O_MIN1,
    output logic [BCD_W-1:0] O_MIN0,
    output logic             O_CARRY_1S,
    output logic             O_OVF,
    output logic             O_LAP_ACTIVE
);

    logic                w_tick;
    logic                w_live_max;
    logic                w_ovf_evt;
    logic [NUM_DIGITS:0] w_en;
    digits_t             w_live;
    digits_t             w_live_nxt;
    logic                w_lap_act_nxt;
    digits_t             w_lap_val_nxt;

    logic                r_lap_act;
    digits_t             r_lap_val;
    digits_t             r_disp;
    logic                r_ovf;
    logic                r_carry;

    assign w_tick     = I_EN_1MS & I_START_EN & ~(SATURATE & r_ovf);
    assign w_live_max = (w_live == MAX_TIME);
    assign w_ovf_evt  = w_tick & w_live_max;
    // In saturate mode the overflowing tick must not reach the digits at all
    assign w_en[0]    = w_tick & ~(SATURATE & w_live_max);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        bcd_digit_cnt #(
            .MODULO (digit_mod(k))
        ) u_cnt (
            .I_CLK     (I_CLK),
            .I_RST     (I_RST),
            .clear     (I_CLEAR_EN),
            .en_in     (w_en[k]),
            .q         (w_live[k]),
            .carry_out (w_en[k+1])
        );
    end

    // Mirror of the digits' next value so the display register tracks live with no lag
    always_comb begin
        w_live_nxt = w_live;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_en[k+1]) begin
                w_live_nxt[k] = '0;
            end else if (w_en[k]) begin
                w_live_nxt[k] = w_live[k] + BCD_W'(1);
            end
        end
    end

    always_comb begin
        w_lap_act_nxt = r_lap_act;
        w_lap_val_nxt = r_lap_val;
        if (I_LAP) begin
            if (!r_lap_act) begin
                w_lap_act_nxt = 1'b1;
                w_lap_val_nxt = w_live;
            end else begin
                w_lap_act_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST || I_CLEAR_EN) begin
            r_lap_act <= 1'b0;
            r_lap_val <= '0;
            r_disp    <= '0;
            r_ovf     <= 1'b0;
            r_carry   <= 1'b0;
        end else begin
            r_lap_act <= w_lap_act_nxt;
            r_lap_val <= w_lap_val_nxt;
            r_disp    <= w_lap_act_nxt ? w_lap_val_nxt : w_live_nxt;
            r_carry   <= w_en[3];
            r_ovf     <= SATURATE ? (r_ovf | w_ovf_evt) : w_ovf_evt;
        end
    end

    assign O_MS0        = r_disp[0];
    assign O_MS1        = r_disp[1];
    assign O_MS2        = r_disp[2];
    assign O_SEC0       = r_disp[3];
    assign O_SEC1       = r_disp[4];
    assign O_MIN0       = r_disp[5];
    assign O_MIN1       = r_disp[6];
    assign O_CARRY_1S   = r_carry;
    assign O_OVF        = r_ovf;
    assign O_LAP_ACTIVE = r_lap_act;

endmodule

// File: tb/tb_sw_time_counter.sv
// Bench for sw_time_counter: a saturating and a wrapping instance share stimulus and are checked
// against a millisecond-count reference model.
module tb_sw_time_counter;

    localparam int TMAX = 3599999;

    logic clk = 1'b0;
    logic rst = 1'b0, en = 1'b0, st = 1'b0, clr = 1'b0, lap = 1'b0;

    logic [3:0] s_ms2, s_ms1, s_ms0, s_sec1, s_sec0, s_min1, s_min0;
    logic [3:0] w_ms2, w_ms1, w_ms0, w_sec1, w_sec0, w_min1, w_min0;
    logic       s_cy, s_ovf, s_lap, w_cy, w_ovf, w_lap;

    logic [27:0] disp_o [2];
    logic        ovf_o  [2];
    logic        cy_o   [2];
    logic        lap_o  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: elapsed ms as a plain integer per instance (0 = saturating, 1 = wrapping)
    int m_t       [2];
    int m_lap_val [2];
    bit m_lap_act [2];
    bit m_ovf     [2];
    bit m_cy      [2];

    logic [27:0] pre_d;

    always #5 clk = ~clk;

    sw_time_counter #(.SATURATE(1'b1)) dut_sat (
        .I_CLK(clk), .I_RST(rst), .I_EN_1MS(en), .I_START_EN(st), .I_CLEAR_EN(clr), .I_LAP(lap),
        .O_MS2(s_ms2), .O_MS1(s_ms1), .O_MS0(s_ms0), .O_SEC1(s_sec1), .O_SEC0(s_sec0),
        .O_MIN1(s_min1), .O_MIN0(s_min0), .O_CARRY_1S(s_cy), .O_OVF(s_ovf), .O_LAP_ACTIVE(s_lap)
    );

    sw_time_counter #(.SATURATE(1'b0)) dut_wrap (
        .I_CLK(clk), .I_RST(rst), .I_EN_1MS(en), .I_START_EN(st), .I_CLEAR_EN(clr), .I_LAP(lap),
        .O_MS2(w_ms2), .O_MS1(w_ms1), .O_MS0(w_ms0), .O_SEC1(w_sec1), .O_SEC0(w_sec0),
        .O_MIN1(w_min1), .O_MIN0(w_min0), .O_CARRY_1S(w_cy), .O_OVF(w_ovf), .O_LAP_ACTIVE(w_lap)
    );

    assign disp_o[0] = {s_min1, s_min0, s_sec1, s_sec0, s_ms2, s_ms1, s_ms0};
    assign disp_o[1] = {w_min1, w_min0, w_sec1, w_sec0, w_ms2, w_ms1, w_ms0};
    assign ovf_o[0] = s_ovf;  assign ovf_o[1] = w_ovf;
    assign cy_o[0]  = s_cy;   assign cy_o[1]  = w_cy;
    assign lap_o[0] = s_lap;  assign lap_o[1] = w_lap;

    function automatic logic [27:0] to_bcd(input int x);
        int ms, s, m;
        ms = x % 1000;
        s  = (x / 1000) % 60;
        m  = x / 60000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
    endfunction

    function automatic logic [27:0] exp_disp(input int i);
        return to_bcd(m_lap_act[i] ? m_lap_val[i] : m_t[i]);
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return 1 time unit after it
    task automatic step(input logic r, input logic e, input logic s, input logic c, input logic l);
        rst = r; en = e; st = s; clr = c; lap = l;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit sat;
            bit tick;
            sat = (i == 0);
            if (r || c) begin
                m_t[i] = 0; m_lap_val[i] = 0; m_lap_act[i] = 0; m_ovf[i] = 0; m_cy[i] = 0;
            end else begin
                tick = e && s && !(sat && m_ovf[i]);
                m_cy[i] = 0;
                if (!sat) m_ovf[i] = 0;
                if (l) begin
                    if (!m_lap_act[i]) begin
                        m_lap_val[i] = m_t[i];
                        m_lap_act[i] = 1;
                    end else begin
                        m_lap_act[i] = 0;
                    end
                end
                if (tick) begin
                    if (m_t[i] == TMAX) begin
                        m_ovf[i] = 1;
                        if (!sat) begin
                            m_t[i]  = 0;
                            m_cy[i] = 1;
                        end
                    end else begin
                        m_t[i]++;
                        m_cy[i] = (m_t[i] % 1000 == 0);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 1, 0, 0);
    endtask

    // Jump the live counters of both instances to a given time, then let the display catch up
    task automatic preload(input int t);
        pre_d = to_bcd(t);
        force dut_sat.g_dig[0].u_cnt.r_q = pre_d[3:0];   force dut_wrap.g_dig[0].u_cnt.r_q = pre_d[3:0];
        force dut_sat.g_dig[1].u_cnt.r_q = pre_d[7:4];   force dut_wrap.g_dig[1].u_cnt.r_q = pre_d[7:4];
        force dut_sat.g_dig[2].u_cnt.r_q = pre_d[11:8];  force dut_wrap.g_dig[2].u_cnt.r_q = pre_d[11:8];
        force dut_sat.g_dig[3].u_cnt.r_q = pre_d[15:12]; force dut_wrap.g_dig[3].u_cnt.r_q = pre_d[15:12];
        force dut_sat.g_dig[4].u_cnt.r_q = pre_d[19:16]; force dut_wrap.g_dig[4].u_cnt.r_q = pre_d[19:16];
        force dut_sat.g_dig[5].u_cnt.r_q = pre_d[23:20]; force dut_wrap.g_dig[5].u_cnt.r_q = pre_d[23:20];
        force dut_sat.g_dig[6].u_cnt.r_q = pre_d[27:24]; force dut_wrap.g_dig[6].u_cnt.r_q = pre_d[27:24];
        #1;
        release dut_sat.g_dig[0].u_cnt.r_q; release dut_wrap.g_dig[0].u_cnt.r_q;
        release dut_sat.g_dig[1].u_cnt.r_q; release dut_wrap.g_dig[1].u_cnt.r_q;
        release dut_sat.g_dig[2].u_cnt.r_q; release dut_wrap.g_dig[2].u_cnt.r_q;
        release dut_sat.g_dig[3].u_cnt.r_q; release dut_wrap.g_dig[3].u_cnt.r_q;
        release dut_sat.g_dig[4].u_cnt.r_q; release dut_wrap.g_dig[4].u_cnt.r_q;
        release dut_sat.g_dig[5].u_cnt.r_q; release dut_wrap.g_dig[5].u_cnt.r_q;
        release dut_sat.g_dig[6].u_cnt.r_q; release dut_wrap.g_dig[6].u_cnt.r_q;
        m_t[0] = t;
        m_t[1] = t;
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (disp_o[i] !== 28'h0 || ovf_o[i] !== 1'b0 || cy_o[i] !== 1'b0 || lap_o[i] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset[%0d]: disp=%h ovf=%b cy=%b lap=%b, required all 0",
                         i, disp_o[i], ovf_o[i], cy_o[i], lap_o[i]);
            end
        end
    endtask

    task automatic test_count_1000();
        int pulses, last;
        pulses = 0; last = -1;
        for (int k = 1; k <= 1000; k++) begin
            step(0, 1, 1, 0, 0);
            if (cy_o[0] === 1'b1) begin
                pulses++;
                last = k;
            end
        end
        n_checks++;
        if (disp_o[0] !== 28'h0001000) begin
            n_errors++;
            $display("FAIL count_1000_disp: got %h required %h", disp_o[0], 28'h0001000);
        end
        n_checks++;
        if (pulses != 1 || last != 1000) begin
            n_errors++;
            $display("FAIL count_1000_carry: %0d pulses last at tick %0d, required 1 at tick 1000", pulses, last);
        end
    endtask

    task automatic test_minute_carry();
        preload(59990);
        ticks(9);
        n_checks++;
        if (disp_o[0] !== 28'h0059999) begin
            n_errors++;
            $display("FAIL minute_pre: got %h required %h", disp_o[0], 28'h0059999);
        end
        ticks(1);
        n_checks++;
        if (disp_o[0] !== 28'h0100000 || cy_o[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL minute_carry: disp=%h cy=%b required %h cy=1", disp_o[0], cy_o[0], 28'h0100000);
        end
    endtask

    task automatic test_lap();
        step(0, 0, 1, 1, 0);
        ticks(250);
        step(0, 1, 1, 0, 1);
        n_checks++;
        if (disp_o[0] !== 28'h0000250 || lap_o[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL lap_freeze: disp=%h lap=%b required 0000250 lap=1", disp_o[0], lap_o[0]);
        end
        ticks(500);
        n_checks++;
        if (disp_o[0] !== 28'h0000250 || lap_o[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL lap_hold: disp=%h lap=%b required 0000250 lap=1", disp_o[0], lap_o[0]);
        end
        step(0, 0, 1, 0, 1);
        n_checks++;
        if (disp_o[0] !== 28'h0000751 || lap_o[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL lap_release: disp=%h lap=%b required 0000751 lap=0", disp_o[0], lap_o[0]);
        end
    endtask

    task automatic test_start_gate();
        step(0, 0, 1, 1, 0);
        ticks(7);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0);
        n_checks++;
        if (disp_o[0] !== 28'h0000007) begin
            n_errors++;
            $display("FAIL start_hold: got %h required %h", disp_o[0], 28'h0000007);
        end
        ticks(3);
        n_checks++;
        if (disp_o[0] !== 28'h0000010) begin
            n_errors++;
            $display("FAIL start_resume: got %h required %h", disp_o[0], 28'h0000010);
        end
    endtask

    task automatic test_overflow();
        step(0, 0, 1, 1, 0);
        preload(3599995);
        ticks(4);
        n_checks++;
        if (disp_o[0] !== 28'h5959999 || disp_o[1] !== 28'h5959999) begin
            n_errors++;
            $display("FAIL ovf_max: sat=%h wrap=%h required 5959999", disp_o[0], disp_o[1]);
        end
        ticks(1);
        n_checks++;
        if (disp_o[0] !== 28'h5959999 || ovf_o[0] !== 1'b1 || cy_o[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_sat_edge: disp=%h ovf=%b cy=%b required 5959999 1 0", disp_o[0], ovf_o[0], cy_o[0]);
        end
        n_checks++;
        if (disp_o[1] !== 28'h0 || ovf_o[1] !== 1'b1 || cy_o[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_wrap_edge: disp=%h ovf=%b cy=%b required 0000000 1 1", disp_o[1], ovf_o[1], cy_o[1]);
        end
        step(0, 0, 1, 0, 0);
        n_checks++;
        if (ovf_o[1] !== 1'b0 || cy_o[1] !== 1'b0 || ovf_o[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_width: wrap ovf=%b cy=%b sat ovf=%b required 0 0 1", ovf_o[1], cy_o[1], ovf_o[0]);
        end
        ticks(5);
        n_checks++;
        if (disp_o[0] !== 28'h5959999 || ovf_o[0] !== 1'b1 || disp_o[1] !== 28'h0000005) begin
            n_errors++;
            $display("FAIL ovf_after: sat=%h ovf=%b wrap=%h required 5959999 1 0000005",
                     disp_o[0], ovf_o[0], disp_o[1]);
        end
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (disp_o[i] !== 28'h0 || ovf_o[i] !== 1'b0) begin
                n_errors++;
                $display("FAIL ovf_clear[%0d]: disp=%h ovf=%b required 0 0", i, disp_o[i], ovf_o[i]);
            end
        end
    endtask

    task automatic test_clear_collide();
        for (int pass = 0; pass < 2; pass++) begin
            step(0, 0, 1, 1, 0);
            ticks(500);
            step(0, 0, 1, 0, 1);
            ticks(499);
            // Live sits at 999 so the colliding tick would otherwise carry
            if (pass == 0) step(0, 1, 1, 1, 1);
            else           step(1, 1, 1, 0, 1);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (disp_o[i] !== 28'h0 || lap_o[i] !== 1'b0 || cy_o[i] !== 1'b0 || ovf_o[i] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL collide%0d[%0d]: disp=%h lap=%b cy=%b ovf=%b required all 0",
                             pass, i, disp_o[i], lap_o[i], cy_o[i], ovf_o[i]);
                end
            end
            step(pass == 1, 1, 1, pass == 0, 0);
            step(pass == 1, 1, 1, pass == 0, 1);
            n_checks++;
            if (disp_o[0] !== 28'h0 || lap_o[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL held_clear%0d: disp=%h lap=%b required 0 0", pass, disp_o[0], lap_o[0]);
            end
        end
    endtask

    task automatic test_random();
        step(0, 0, 1, 1, 0);
        preload(3599000);
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 499) == 0), ($urandom_range(0, 39) == 0));
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (disp_o[i] !== exp_disp(i) || ovf_o[i] !== m_ovf[i] || cy_o[i] !== m_cy[i] ||
                    lap_o[i] !== m_lap_act[i]) begin
                    n_errors++;
                    $display("FAIL random[%0d] cyc %0d: disp=%h ovf=%b cy=%b lap=%b required %h %b %b %b",
                             i, k, disp_o[i], ovf_o[i], cy_o[i], lap_o[i],
                             exp_disp(i), m_ovf[i], m_cy[i], m_lap_act[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_t[i] = 0; m_lap_val[i] = 0; m_lap_act[i] = 0; m_ovf[i] = 0; m_cy[i] = 0;
        end
        @(negedge clk);
        test_reset();
        test_count_1000();
        test_minute_carry();
        test_lap();
        test_start_gate();
        test_overflow();
        test_clear_collide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
